// File: rtl/noc_pkg.sv
// Shared router constants: packet layout, header bit positions, hop-update modes.
package noc_pkg;

  localparam int PACKET_SIZE = 64;

  localparam int VC_BIT   = 63;
  localparam int HDIR_BIT = 62;
  localparam int VDIR_BIT = 61;

  localparam int HHOP_HI = 55;
  localparam int HHOP_LO = 52;
  localparam int VHOP_HI = 51;
  localparam int VHOP_LO = 48;

  localparam int HOP_DEC_NONE = 0;
  localparam int HOP_DEC_H    = 1;
  localparam int HOP_DEC_V    = 2;

  // A zero hop field wraps to 4'hF; that is an upstream routing error, not caught here.
  function automatic logic [PACKET_SIZE-1:0] apply_hop(input logic [PACKET_SIZE-1:0] pkt,
                                                       input int mode);
    logic [PACKET_SIZE-1:0] r;
    r = pkt;
    if (mode == HOP_DEC_H) r[HHOP_HI:HHOP_LO] = pkt[HHOP_HI:HHOP_LO] - 4'd1;
    if (mode == HOP_DEC_V) r[VHOP_HI:VHOP_LO] = pkt[VHOP_HI:VHOP_LO] - 4'd1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first eligible index after ptr, modulo N. Purely combinational.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  int            c;
  logic [IW-1:0] ci;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    c   = 0;
    ci  = '0;
    for (int k = 1; k <= N; k++) begin
      c  = (int'(ptr) + k) % N;
      ci = IW'(c);
      if (!vld && elig[ci]) begin
        vld     = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/vc_output_arbiter.sv
// Per-output-port arbiter: captures one packet per VC (internal VC = polarity), drains the other VC.
// Grant-to-send one cycle minimum; a full internal slot withholds grants, ro=0 holds the external slot.
module vc_output_arbiter
  import noc_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int HOP_DEC = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         polarity,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*PACKET_SIZE-1:0] req_data,
  output logic [N_REQ-1:0]             gnt,
  output logic                         so,
  input  logic                         ro,
  output logic [PACKET_SIZE-1:0]       dout
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IW-1:0] PTR_RST = IW'(N_REQ - 1);

  logic [1:0]             slot_full_q, slot_full_d;
  logic [PACKET_SIZE-1:0] slot_data_q [2];
  logic [PACKET_SIZE-1:0] slot_data_d [2];
  logic [IW-1:0]          rr_ptr_q [2];
  logic [IW-1:0]          rr_ptr_d [2];

  logic [PACKET_SIZE-1:0] req_pkt [N_REQ];
  logic [N_REQ-1:0]       elig;
  logic [N_REQ-1:0]       arb_gnt;
  logic [IW-1:0]          win_idx;
  logic                   arb_vld;
  logic                   ext_vc;
  logic                   take;

  assign ext_vc = ~polarity;

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign req_pkt[i] = req_data[i*PACKET_SIZE +: PACKET_SIZE];
    assign elig[i]    = req[i] & (req_pkt[i][VC_BIT] == polarity);
  end

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .elig (elig),
    .ptr  (rr_ptr_q[polarity]),
    .gnt  (arb_gnt),
    .idx  (win_idx),
    .vld  (arb_vld)
  );

  // Gating with reset keeps gnt low while reset is held even if requesters are asserting.
  assign take = reset & arb_vld & ~slot_full_q[polarity];
  assign gnt  = take ? arb_gnt : '0;
  assign so   = reset & slot_full_q[ext_vc] & ro;
  assign dout = so ? slot_data_q[ext_vc] : '0;

  always_comb begin
    slot_full_d = slot_full_q;
    slot_data_d = slot_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (so) slot_full_d[ext_vc] = 1'b0;
    if (take) begin
      slot_full_d[polarity] = 1'b1;
      slot_data_d[polarity] = apply_hop(req_pkt[win_idx], HOP_DEC);
      rr_ptr_d[polarity]    = win_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_full_q <= '0;
      slot_data_q <= '{default: '0};
      rr_ptr_q    <= '{PTR_RST, PTR_RST};
    end else begin
      slot_full_q <= slot_full_d;
      slot_data_q <= slot_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_vc_output_arbiter.sv
// Directed bench for vc_output_arbiter (HOP_DEC=1): expected packets queued at grant, checked at send.
module tb_vc_output_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         polarity;
  logic [3:0]   req;
  logic [255:0] req_data;
  logic [3:0]   gnt;
  logic         so;
  logic         ro;
  logic [63:0]  dout;

  logic [63:0]  pk [4];
  logic [63:0]  exp_q [$];
  logic [63:0]  saved;
  logic         refill;
  int           nid;
  int           tests;
  int           fails;

  assign req_data = {pk[3], pk[2], pk[1], pk[0]};

  vc_output_arbiter #(.N_REQ(4), .HOP_DEC(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .so       (so),
    .ro       (ro),
    .dout     (dout)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] make_pkt(input logic vc, input int id);
    return {vc, 7'h00, 4'h2, 4'h7, 16'hBEEF, 32'(id)};
  endfunction

  function automatic logic [63:0] hop_h(input logic [63:0] p);
    logic [63:0] r;
    r = p;
    r[55:52] = p[55:52] - 4'd1;
    return r;
  endfunction

  task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // One cycle: check outputs, queue any capture, take the edge, flip polarity, dequeue winner.
  task automatic run_cycle(input logic [3:0] eg, input logic es, input string tag);
    logic [3:0]  g;
    logic [63:0] e;
    #1;
    g = gnt;
    tests++;
    assert (g === eg) else begin
      fails++;
      $error("FAIL %s gnt: got %b expected %b", tag, g, eg);
    end
    tests++;
    assert (so === es) else begin
      fails++;
      $error("FAIL %s so: got %b expected %b", tag, so, es);
    end
    if (so === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL %s dout: got send of %h expected no pending packet", tag, dout);
      end else begin
        e = exp_q.pop_front();
        chk64({tag, " dout"}, dout, e);
      end
    end else begin
      chk64({tag, " dout_idle"}, dout, 64'h0);
    end
    for (int i = 0; i < 4; i++) if (g[i]) exp_q.push_back(hop_h(pk[i]));
    @(posedge clk);
    #1;
    polarity = ~polarity;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) begin
        if (refill) begin
          pk[i] = make_pkt(pk[i][63], nid);
          nid++;
        end else begin
          req[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0; nid = 1; refill = 1'b0;
    reset = 1'b0; polarity = 1'b0; ro = 1'b1; req = 4'b0001;
    for (int i = 0; i < 4; i++) pk[i] = 64'h0;
    #2;
    // reset state, with a live request that must not be granted
    #1;
    tests++;
    assert (gnt === 4'b0000) else begin fails++; $error("FAIL rst gnt: got %b expected 0000", gnt); end
    tests++;
    assert (so === 1'b0) else begin fails++; $error("FAIL rst so: got %b expected 0", so); end
    chk64("rst dout", dout, 64'h0);
    #10;
    req = 4'b0000;
    reset = 1'b1;

    // idle with polarity toggling
    for (int k = 0; k < 4; k++) run_cycle(4'b0000, 1'b0, "idle");

    // round robin, all four hold VC0 packets
    for (int i = 0; i < 4; i++) begin pk[i] = make_pkt(1'b0, nid); nid++; end
    req = 4'b1111; refill = 1'b1; ro = 1'b1;
    run_cycle(4'b0001, 1'b0, "rr0");
    run_cycle(4'b0000, 1'b1, "rr0s");
    run_cycle(4'b0010, 1'b0, "rr1");
    run_cycle(4'b0000, 1'b1, "rr1s");
    run_cycle(4'b0100, 1'b0, "rr2");
    run_cycle(4'b0000, 1'b1, "rr2s");
    run_cycle(4'b1000, 1'b0, "rr3");
    run_cycle(4'b0000, 1'b1, "rr3s");
    run_cycle(4'b0001, 1'b0, "rr4");
    run_cycle(4'b0000, 1'b1, "rr4s");
    req = 4'b0000; refill = 1'b0;

    // horizontal hop decrement
    pk[2] = 64'h0030_DEAD_EA57_0000;
    req = 4'b0100;
    run_cycle(4'b0100, 1'b0, "hop_gnt");
    #1;
    chk64("hop_lit", dout, 64'h0020_DEAD_EA57_0000);
    run_cycle(4'b0000, 1'b1, "hop_send");

    // downstream stall with VC0 slot full
    pk[0] = make_pkt(1'b0, nid); nid++;
    pk[1] = make_pkt(1'b0, nid); nid++;
    req = 4'b0011; ro = 1'b0;
    run_cycle(4'b0001, 1'b0, "stall1");
    run_cycle(4'b0000, 1'b0, "stall2");
    run_cycle(4'b0000, 1'b0, "stall3");
    run_cycle(4'b0000, 1'b0, "stall4");
    run_cycle(4'b0000, 1'b0, "stall5");
    run_cycle(4'b0000, 1'b0, "stall6");
    ro = 1'b1;
    run_cycle(4'b0000, 1'b0, "unstall1");
    run_cycle(4'b0000, 1'b1, "unstall_send");
    run_cycle(4'b0010, 1'b0, "unstall_gnt");
    run_cycle(4'b0000, 1'b1, "unstall_send2");

    // two VCs in opposite phases
    pk[1] = make_pkt(1'b1, nid); nid++;
    pk[3] = make_pkt(1'b0, nid); nid++;
    req = 4'b1010;
    run_cycle(4'b1000, 1'b0, "vc_a");
    run_cycle(4'b0010, 1'b1, "vc_b");
    run_cycle(4'b0000, 1'b1, "vc_c");
    run_cycle(4'b0000, 1'b0, "vc_d");

    // independent pointers: VC0 ptr=3 picks 0, VC1 ptr=1 picks 2
    pk[0] = make_pkt(1'b0, nid); nid++;
    pk[1] = make_pkt(1'b1, nid); nid++;
    pk[2] = make_pkt(1'b1, nid); nid++;
    pk[3] = make_pkt(1'b0, nid); nid++;
    req = 4'b1111;
    run_cycle(4'b0001, 1'b0, "ptr_a");
    run_cycle(4'b0100, 1'b1, "ptr_b");
    run_cycle(4'b1000, 1'b1, "ptr_c");
    run_cycle(4'b0010, 1'b1, "ptr_d");
    run_cycle(4'b0000, 1'b1, "ptr_e");
    run_cycle(4'b0000, 1'b0, "ptr_f");

    // asynchronous reset with both slots full
    pk[0] = make_pkt(1'b0, nid); nid++;
    pk[1] = make_pkt(1'b1, nid); nid++;
    saved = hop_h(pk[1]);
    req = 4'b0011; ro = 1'b0;
    run_cycle(4'b0001, 1'b0, "fill0");
    run_cycle(4'b0010, 1'b0, "fill1");
    pk[2] = make_pkt(1'b0, nid); nid++;
    req = 4'b0100; ro = 1'b1;
    #1;
    tests++;
    assert (so === 1'b1) else begin fails++; $error("FAIL prerst so: got %b expected 1", so); end
    chk64("prerst dout", dout, saved);
    reset = 1'b0;
    #1;
    tests++;
    assert (so === 1'b0) else begin fails++; $error("FAIL arst so: got %b expected 0", so); end
    chk64("arst dout", dout, 64'h0);
    tests++;
    assert (gnt === 4'b0000) else begin fails++; $error("FAIL arst gnt: got %b expected 0000", gnt); end
    exp_q.delete();
    @(posedge clk);
    #2;
    polarity = 1'b0;
    for (int i = 0; i < 4; i++) begin pk[i] = make_pkt(1'b0, nid); nid++; end
    req = 4'b1111;
    reset = 1'b1;
    run_cycle(4'b0001, 1'b0, "post_a");
    run_cycle(4'b0000, 1'b1, "post_b");
    run_cycle(4'b0010, 1'b0, "post_c");
    run_cycle(4'b0000, 1'b1, "post_d");
    req = 4'b0000;
    run_cycle(4'b0000, 1'b0, "post_e");

    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL drain_all: got %0d unsent packets expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vc_output_arbiter.md
# vc_output_arbiter

One instance sits on each output port of the gold_router: cw, ccw, ns, sn and pe. It shares that output among the input buffers that want it, using round-robin arbitration per virtual channel. Polarity decides which VC is filled internally and which VC is drained on the external link. It holds one 64-bit output slot per VC and, where the port requires it, decrements the packet's hop field on capture.

## Interface
- PACKET_SIZE, 64: packet width; bit 63 is the VC bit.
- N_REQ, 4: number of requesting input buffers.
- HOP_DEC, 0: hop update applied on capture.
  - 0: none (PE port).
  - 1: decrement bits [55:52] (horizontal).
  - 2: decrement bits [51:48] (vertical).

Ports:
- clk, input, 1: clock.
- reset, input, 1: reset, asynchronous, active-low.
- polarity, input, 1: global phase; toggles every cycle outside reset.
- req, input, N_REQ: request from input buffer i.
- req_data, input, N_REQ*PACKET_SIZE: packet from buffer i, flattened; buffer i occupies slice [i*PACKET_SIZE +: PACKET_SIZE].
- gnt, output, N_REQ: one-hot, combinational; buffer i dequeues on the edge where gnt[i]=1.
- so, output, 1: send-out to the downstream router or PE.
- ro, input, 1: downstream ready.
- dout, output, PACKET_SIZE: outgoing packet.

## Operation
- Internal VC = polarity; external VC = ~polarity.
- Slot state: slot_full[1:0], slot_data[1:0].
- Eligibility: requester i is eligible when req[i]=1 and req_data[i][63]==polarity.
- Grant: issued only if slot_full[polarity]==0 and at least one requester is eligible.
  - Exactly one gnt bit is set.
  - Winner is the first eligible index after rr_ptr[polarity], searching modulo N_REQ.
  - Otherwise gnt=0.
- Capture on the edge with a grant:
  - slot_data[polarity] ← winner packet with the hop field per HOP_DEC applied.
  - slot_full[polarity] ← 1.
  - rr_ptr[polarity] ← winner index.
- Hop arithmetic: 4-bit unsigned subtract by 1. A field of 0 wraps to 4'hF; this is an upstream routing error and is not flagged. All other bits pass through unchanged.
- Drain:
  - so = slot_full[~polarity] & ro.
  - dout = slot_data[~polarity] when so=1, else 0.
  - The edge with so=1 clears slot_full[~polarity].
- The two rr_ptr registers are independent; each updates only on a grant for its own VC.

## Timing
- Reset asserted, asynchronously:
  - slot_full=0 and slot_data=0.
  - Both rr_ptr = N_REQ-1, so index 0 wins first.
  - Outputs so=0, dout=0, gnt=0.
  - A packet held in a slot when reset asserts mid-operation is dropped.
- Latency: grant at edge T → earliest so at cycle T+1, because the polarity flip makes that slot external. Minimum one cycle from dequeue to send.
- Capture and drain in the same cycle always target different VCs; both happen.
- Slot full at its internal phase: no grant. Requesters hold req; this is backpressure.
- ro=0 at the external phase: slot stays full, so=0; retry on the next external phase, two cycles later.
- A slot cannot be captured and drained on the same edge, since one VC is either internal or external in a given cycle.
- Sustained throughput: one packet per VC every 2 cycles, so the port can send every cycle.

## Structure
- Shared package noc_pkg holds:
  - PACKET_SIZE.
  - Bit positions VC_BIT=63, HDIR_BIT=62, VDIR_BIT=61.
  - Ranges HHOP=[55:52], VHOP=[51:48].
  - The HOP_DEC encodings.
- One sub-module, rr_arbiter: N_REQ-wide round-robin pick.
  - Inputs: eligible vector and pointer.
  - Outputs: one-hot grant and encoded index.
  - Instantiated once, fed by the rr_ptr selected by polarity.

## Test plan
- Reset with no traffic, then polarity toggling → so=0, gnt=0 throughout; dout=0.
- HOP_DEC=1: req[2]=1, packet 0x0030_DEAD_EA57_0000 (VC0, HHOP=3) while polarity=0:
  - gnt=4'b0100 that cycle.
  - Next cycle (polarity=1, ro=1): so=1, dout=0x0020_DEAD_EA57_0000.
- All four requesters hold VC0 packets, ro=1:
  - Grants on successive polarity=0 cycles follow 0,1,2,3,0.
  - Each packet appears on dout exactly once, in that order.
- ro=0 for 6 cycles with slot VC0 full:
  - No second VC0 grant while the slot is full.
  - so stays 0.
  - After ro=1 the packet sends at the next polarity=1 cycle.
  - The next VC0 grant follows at the next polarity=0 cycle.
- VC1 packet on req[1] and VC0 packet on req[3] both held:
  - Each is granted only in its matching polarity.
  - so asserts on consecutive cycles.
  - Both rr_ptr values update independently.
- Reset asserted mid-flight with both slots full → so=0 immediately, without waiting for clk. After release, index 0 wins the first grant.
